// File: rtl/alu_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_pkg
// Shared definitions for the Kolache ALU front-end: opcode encoding, FSM state
// encoding and the default operand width.
// -----------------------------------------------------------------------------
package alu_issue_ctrl_pkg;

  localparam int ALU_WIDTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_ADD = 3'b011,
    OP_SUB = 3'b100,
    OP_MUL = 3'b101,
    OP_SLT = 3'b110,
    OP_ILL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_issue_ctrl_logic.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_logic
// Combinational single-cycle datapath: AND/OR/XOR, ADD, SUB, SLT and the
// illegal opcode. MUL is not handled here (result reads as zero for it).
// Ports:
//   a, b   : operands
//   op     : opcode
//   y      : result
//   zero, carry, ovf, err : flags for y
// -----------------------------------------------------------------------------
module alu_issue_ctrl_logic
  import alu_issue_ctrl_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] and_v;
  logic [WIDTH-1:0] or_v;
  logic [WIDTH-1:0] xor_v;
  logic [WIDTH:0]   sum_v;
  logic [WIDTH:0]   diff_v;
  logic             slt_v;

  // Bit-sliced logic unit, one gate per bit.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bitwise
    assign and_v[gi] = a[gi] & b[gi];
    assign or_v[gi]  = a[gi] | b[gi];
    assign xor_v[gi] = a[gi] ^ b[gi];
  end

  // One extra bit captures carry-out / borrow.
  assign sum_v  = {1'b0, a} + {1'b0, b};
  assign diff_v = {1'b0, a} - {1'b0, b};
  assign slt_v  = $signed(a) < $signed(b);

  always_comb begin
    y     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    err   = 1'b0;
    case (op)
      OP_AND: y = and_v;
      OP_OR:  y = or_v;
      OP_XOR: y = xor_v;
      OP_ADD: begin
        y     = sum_v[WIDTH-1:0];
        carry = sum_v[WIDTH];
        ovf   = (a[MSB] == b[MSB]) && (sum_v[MSB] != a[MSB]);
      end
      OP_SUB: begin
        y     = diff_v[WIDTH-1:0];
        carry = diff_v[WIDTH];  // borrow: unsigned a < b
        ovf   = (a[MSB] != b[MSB]) && (diff_v[MSB] != a[MSB]);
      end
      OP_SLT: y = {{(WIDTH-1){1'b0}}, slt_v};
      OP_ILL: err = 1'b1;
      default: y = '0;  // MUL is computed by the sequential datapath
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Sequential ALU front-end. Accepts one op through in_valid/in_ready, evaluates
// single-cycle ops via alu_issue_ctrl_logic, runs MUL as a WIDTH-cycle
// shift-add, and holds the registered result until retired downstream.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : input handshake (op, a, b sampled on accept)
//   out_valid/out_ready : output handshake
//   y, zero, carry, ovf, err : registered result and flags
//   busy              : high while the multiplier is iterating
// -----------------------------------------------------------------------------
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             err,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] y_q;
  logic             zero_q;
  logic             carry_q;
  logic             ovf_q;
  logic             err_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [WIDTH-1:0] lg_y;
  logic             lg_zero;
  logic             lg_carry;
  logic             lg_ovf;
  logic             lg_err;

  logic             accept;

  alu_issue_ctrl_logic #(.WIDTH(WIDTH)) u_logic (
    .a     (a),
    .b     (b),
    .op    (op),
    .y     (lg_y),
    .zero  (lg_zero),
    .carry (lg_carry),
    .ovf   (lg_ovf),
    .err   (lg_err)
  );

  // Gated by rst so upstream never sees ready while reset is asserted.
  assign in_ready = (state_q == S_IDLE) && !rst;
  assign accept   = in_valid && in_ready;

  // One shift-add step; the carry out of the accumulator is dropped.
  assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      y_q         <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              mcand_q  <= a;
              mplier_q <= b;
              acc_q    <= '0;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= S_MUL;
            end else begin
              y_q         <= lg_y;
              zero_q      <= lg_zero;
              carry_q     <= lg_carry;
              ovf_q       <= lg_ovf;
              err_q       <= lg_err;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          // cnt counts completed steps; the WIDTH-th step finishes the product,
          // so the counter is held there instead of wrapping.
          if (cnt_q == CNT_LAST) begin
            y_q         <= acc_d;
            zero_q      <= (acc_d == '0);
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign y         = y_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule
